bus_arbiter_4: RTL and testbench
================================

BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles a granted transaction may wait for mem_ready before abort (range 1..65535).
REQ-002 Parameter CNT_W, default 16, width of the timeout counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low; takes effect on the clk edge where rst_n=0.
REQ-005 req  input  4  per-requester access request; bit i = requester i.
REQ-006 mem_ready  input  1  shared memory completion strobe; valid only while mem_valid=1.
REQ-007 grant  output  4  one-hot (or zero) grant to the current owner.
REQ-008 sel  output  2  select code driving the shared 4:1 address/data mux; equals index of granted requester.
REQ-009 mem_valid  output  1  transaction active toward shared memory.
REQ-010 done  output  4  one-cycle completion pulse to the owner.
REQ-011 err  output  1  one-cycle pulse with done when the transaction was aborted by timeout.
REQ-012 busy_cnt  output  CNT_W  cycles elapsed in the current transaction, saturating at TIMEOUT.

Function
REQ-013 Two states: IDLE, BUSY; all outputs registered.
REQ-014 Round-robin pointer ptr[1:0]; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); first set req bit wins.
REQ-015 IDLE with req!=0 at edge N: at N+1 state=BUSY, grant=one-hot(winner), sel=winner, mem_valid=1, busy_cnt=0.
REQ-016 IDLE with req=0: remain IDLE; grant=0, mem_valid=0, sel holds last value.
REQ-017 BUSY: grant, sel, mem_valid constant until exit; req changes (including owner dropping req) ignored.
REQ-018 BUSY, mem_ready=1 at edge M: at M+1 state=IDLE, grant=0, mem_valid=0, done[sel]=1, err=0, ptr=sel+1 mod 4 (wraps 3->0).
REQ-019 BUSY, mem_ready=0: busy_cnt increments by 1 per cycle; when busy_cnt=TIMEOUT-1 at an edge without mem_ready, next cycle exits as REQ-018 but with err=1.
REQ-020 mem_ready and timeout in same cycle: treated as normal completion, err=0.
REQ-021 Minimum spacing: done at M+1; next grant earliest M+2 (one IDLE cycle between transactions).
REQ-022 Owner still requesting at IDLE re-arbitrates at lowest priority via ptr rotation.
REQ-023 grant never has more than one bit set; grant!=0 iff mem_valid=1.
REQ-024 mem_ready while IDLE ignored; no done, no state change.
REQ-025 done and err are zero in all cycles except the single exit cycle.

Reset
REQ-026 rst_n=0 at any edge: state=IDLE, ptr=0, grant=0, sel=0, mem_valid=0, done=0, err=0, busy_cnt=0.
REQ-027 Reset during BUSY aborts the transaction silently: no done, no err pulse.
REQ-028 First edge with rst_n=1 behaves as IDLE per REQ-015/016.

Verification
REQ-029 After reset, req=4'b1010 held: grant=4'b0010, sel=1 next cycle; mem_ready after 3 cycles -> done=4'b0010; next grant=4'b1000, sel=3, ptr=0 after completion.
REQ-030 req=4'b1111 continuously, mem_ready=1 each BUSY cycle: grant sequence 0001,0010,0100,1000,0001 with one IDLE cycle between each.
REQ-031 TIMEOUT=4, grant req 2, mem_ready never: mem_valid for 4 cycles, then done=4'b0100 and err=1 together for one cycle, busy_cnt reached 3.
REQ-032 TIMEOUT=4, mem_ready=1 on the 4th BUSY cycle: done pulse, err=0.
REQ-033 Owner drops req in BUSY, other req rises: grant/sel unchanged until mem_ready; mem_ready in IDLE produces no done.
REQ-034 rst_n=0 mid-BUSY: next cycle all outputs zero, no done/err; after release req=4'b0001 -> grant=4'b0001.

Source files
------------

// File: rtl/bus_arbiter_4.sv
// Four-way round-robin arbiter for a shared memory port; grant and all outputs follow req by one cycle.
// One transaction at a time, closed by mem_ready or by timeout abort; requests are held off while BUSY.
module bus_arbiter_4 #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic             mem_ready,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic             mem_valid,
  output logic [3:0]       done,
  output logic             err,
  output logic [CNT_W-1:0] busy_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic             mem_valid_q, mem_valid_d;
  logic [3:0]       done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

  logic [1:0]       win;
  logic             found;
  logic [1:0]       idx;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    mem_valid_d = mem_valid_q;
    done_d      = 4'b0000;
    err_d       = 1'b0;
    busy_cnt_d  = busy_cnt_q;

    case (state_q)
      IDLE: begin
        grant_d     = 4'b0000;
        mem_valid_d = 1'b0;
        if (found) begin
          state_d     = BUSY;
          grant_d     = 4'b0001 << win;
          sel_d       = win;
          mem_valid_d = 1'b1;
          busy_cnt_d  = '0;
        end
      end
      BUSY: begin
        // Completion wins over a coincident timeout.
        if (mem_ready || (busy_cnt_q >= LAST_CNT)) begin
          state_d     = IDLE;
          grant_d     = 4'b0000;
          mem_valid_d = 1'b0;
          done_d      = 4'b0001 << sel_q;
          err_d       = !mem_ready;
          ptr_d       = sel_q + 2'd1;
        end else if (busy_cnt_q < SAT_CNT) begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        grant_d     = 4'b0000;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      grant_q     <= 4'b0000;
      sel_q       <= 2'd0;
      mem_valid_q <= 1'b0;
      done_q      <= 4'b0000;
      err_q       <= 1'b0;
      busy_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      mem_valid_q <= mem_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign mem_valid = mem_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4 with a short timeout so abort paths are reachable.
module tb_bus_arbiter_4;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic             mem_ready;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic             mem_valid;
  logic [3:0]       done;
  logic             err;
  logic [CNT_W-1:0] busy_cnt;

  int vectors;
  int miscompares;

  bus_arbiter_4 #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mem_ready (mem_ready),
    .grant     (grant),
    .sel       (sel),
    .mem_valid (mem_valid),
    .done      (done),
    .err       (err),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge, then check the structural grant invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    chk("grant_vs_valid", 32'(grant != 4'b0000), 32'(mem_valid));
  endtask

  task automatic chk_idle_pulse(input string tag, input logic [3:0] exp_done, input logic exp_err);
    chk({tag, "_grant"}, grant, 4'b0000);
    chk({tag, "_valid"}, mem_valid, 1'b0);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, err, exp_err);
  endtask

  logic [3:0] rr_seq [5];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;

    rst_n = 1'b0; req = 4'b0000; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_sel", sel, 2'd0);
    chk("rst_valid", mem_valid, 1'b0);
    chk("rst_done", done, 4'b0000);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", busy_cnt, 16'd0);

    // Two requesters, pointer at 0: requester 1 first, then 3.
    rst_n = 1'b1; req = 4'b1010;
    tick();
    chk("a_grant", grant, 4'b0010);
    chk("a_sel", sel, 2'd1);
    chk("a_valid", mem_valid, 1'b1);
    chk("a_cnt0", busy_cnt, 16'd0);
    tick(); tick();
    chk("a_cnt2", busy_cnt, 16'd2);
    chk("a_hold", grant, 4'b0010);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk_idle_pulse("a_exit", 4'b0010, 1'b0);
    tick();
    chk("b_grant", grant, 4'b1000);
    chk("b_sel", sel, 2'd3);
    chk("b_done", done, 4'b0000);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; req = 4'b0000;
    chk_idle_pulse("b_exit", 4'b1000, 1'b0);
    tick();
    chk("b_sel_hold", sel, 2'd3);
    chk("b_done_clr", done, 4'b0000);

    // All four requesting with immediate completion: full rotation from ptr 0.
    req = 4'b1111; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_grant", grant, rr_seq[i]);
      chk("rr_valid", mem_valid, 1'b1);
      chk("rr_done_busy", done, 4'b0000);
      tick();
      chk_idle_pulse("rr_exit", rr_seq[i], 1'b0);
    end
    req = 4'b0000; mem_ready = 1'b0;
    tick();
    chk("rr_done_clr", done, 4'b0000);

    // mem_ready while idle does nothing.
    mem_ready = 1'b1;
    tick();
    chk_idle_pulse("idle_ready", 4'b0000, 1'b0);
    mem_ready = 1'b0;

    // Timeout abort on requester 2: four valid cycles, then done+err.
    req = 4'b0100;
    tick();
    chk("to_grant", grant, 4'b0100);
    req = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("to_valid", mem_valid, 1'b1);
      chk("to_cnt", busy_cnt, 16'(i));
      chk("to_done_busy", done, 4'b0000);
      chk("to_err_busy", err, 1'b0);
    end
    tick();
    chk_idle_pulse("to_exit", 4'b0100, 1'b1);
    tick();
    chk_idle_pulse("to_after", 4'b0000, 1'b0);

    // Completion on the same edge the timeout would fire: no error.
    req = 4'b0100;
    tick();
    chk("tr_grant", grant, 4'b0100);
    req = 4'b0000;
    tick(); tick(); tick();
    chk("tr_cnt3", busy_cnt, 16'd3);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk_idle_pulse("tr_exit", 4'b0100, 1'b0);
    tick();

    // Owner drops, another raises: grant frozen until completion.
    req = 4'b1000;
    tick();
    chk("own_grant", grant, 4'b1000);
    req = 4'b0001;
    tick();
    chk("own_hold1", grant, 4'b1000);
    chk("own_sel1", sel, 2'd3);
    tick();
    chk("own_hold2", grant, 4'b1000);
    mem_ready = 1'b1;
    tick();
    req = 4'b0000;
    chk_idle_pulse("own_exit", 4'b1000, 1'b0);
    tick();
    chk_idle_pulse("own_idle_rdy", 4'b0000, 1'b0);
    mem_ready = 1'b0;

    // Reset in the middle of a transaction.
    req = 4'b0010;
    tick();
    chk("mr_grant", grant, 4'b0010);
    tick();
    rst_n = 1'b0;
    tick();
    chk_idle_pulse("mr_rst", 4'b0000, 1'b0);
    chk("mr_sel", sel, 2'd0);
    chk("mr_cnt", busy_cnt, 16'd0);
    rst_n = 1'b1; req = 4'b0001;
    tick();
    chk("mr_regrant", grant, 4'b0001);
    chk("mr_resel", sel, 2'd0);
    chk("mr_noerr", err, 1'b0);
    mem_ready = 1'b1; req = 4'b0000;
    tick();
    mem_ready = 1'b0;
    chk_idle_pulse("mr_exit", 4'b0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
